// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to 16'h4014 stalls the CPU and copies the 256-byte page
// {page,8'h00}..{page,8'hFF} to 16'h2004 as alternating read/write bus cycles.
// All state updates on the falling edge of i_clk, gated by i_clk_en.
//
// Ports:
//   i_clk, i_reset_n          clock (falling-edge active), async active-low reset
//   i_clk_en                  CPU cycle enable
//   i_cpu_rw/address/data     CPU bus as driven by the 6502 (rw: 1=read)
//   o_cpu_rdy                 1 = CPU may run, 0 = CPU stalled
//   o_dma_active              1 = DMA owns the bus (o_rw/o_address/o_data valid)
//   o_rw/o_address/o_data     DMA bus master outputs
//   i_data                    read data returned to the DMA
//
// Optional build macro OAM_DMA_DEBUG_EN adds o_debug_state (3 bits) and o_debug_count (8 bits).
module oam_dma (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_clk_en,
  input  logic        i_cpu_rw,
  input  logic [15:0] i_cpu_address,
  input  logic [7:0]  i_cpu_data,
  output logic        o_cpu_rdy,
  output logic        o_dma_active,
  output logic        o_rw,
  output logic [15:0] o_address,
  output logic [7:0]  o_data,
  input  logic [7:0]  i_data
`ifdef OAM_DMA_DEBUG_EN
  ,
  output logic [2:0]  o_debug_state,
  output logic [7:0]  o_debug_count
`endif
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHalt  = 3'd1,
    StAlign = 3'd2,
    StRead  = 3'd3,
    StWrite = 3'd4
  } state_e;

  state_e     r_state;
  logic       r_put;
  logic [7:0] r_count;
  logic [7:0] r_page;
  logic [7:0] r_latch;

  logic w_trigger;
  assign w_trigger = ~i_cpu_rw && (i_cpu_address == 16'h4014);

  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StIdle;
      r_put   <= 1'b0;
      r_count <= 8'h00;
      r_page  <= 8'h00;
      r_latch <= 8'h00;
    end else if (i_clk_en) begin
      r_put <= ~r_put;
      unique case (r_state)
        StIdle: begin
          // A trigger while busy falls outside this branch and is ignored.
          if (w_trigger) begin
            r_page  <= i_cpu_data;
            r_count <= 8'h00;
            r_state <= StHalt;
          end
        end
        StHalt: begin
          // r_put flips on this edge: r_put=1 now means the next cycle is a get cycle.
          if (r_put) r_state <= StRead;
          else       r_state <= StAlign;
        end
        StAlign: r_state <= StRead;
        StRead: begin
          r_latch <= i_data;
          r_state <= StWrite;
        end
        StWrite: begin
          if (r_count == 8'hFF) begin
            r_state <= StIdle;
          end else begin
            r_count <= r_count + 8'h01;
            r_state <= StRead;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Outputs decode registered state only; i_data never reaches an output combinationally.
  always_comb begin
    o_cpu_rdy    = 1'b1;
    o_dma_active = 1'b0;
    o_rw         = 1'b1;
    o_address    = 16'h0000;
    o_data       = r_latch;
    unique case (r_state)
      StIdle: ;
      StHalt, StAlign: begin
        o_cpu_rdy    = 1'b0;
        o_dma_active = 1'b1;
        o_address    = {r_page, 8'h00};
      end
      StRead: begin
        o_cpu_rdy    = 1'b0;
        o_dma_active = 1'b1;
        o_address    = {r_page, r_count};
      end
      StWrite: begin
        o_cpu_rdy    = 1'b0;
        o_dma_active = 1'b1;
        o_rw         = 1'b0;
        o_address    = 16'h2004;
      end
      default: ;
    endcase
  end

`ifdef OAM_DMA_DEBUG_EN
  assign o_debug_state = r_state;
  assign o_debug_count = r_count;
`endif

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma. Inputs change just after the falling (active) edge,
// outputs are sampled on the rising edge. Memory returns the low address byte.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_en;
  logic        cpu_rw;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        o_cpu_rdy;
  logic        o_dma_active;
  logic        o_rw;
  logic [15:0] o_address;
  logic [7:0]  o_data;
  logic [7:0]  mem_data;

  int n_cmp  = 0;
  int n_fail = 0;
  bit tb_put = 1'b0;  // bench's own parity model: enabled falling edges since reset, mod 2

  assign mem_data = o_address[7:0];

  always #5 clk = ~clk;

  oam_dma dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_clk_en     (clk_en),
    .i_cpu_rw     (cpu_rw),
    .i_cpu_address(cpu_addr),
    .i_cpu_data   (cpu_data),
    .o_cpu_rdy    (o_cpu_rdy),
    .o_dma_active (o_dma_active),
    .o_rw         (o_rw),
    .o_address    (o_address),
    .o_data       (o_data),
    .i_data       (mem_data)
  );

  task automatic bus_idle();
    cpu_rw   = 1'b1;
    cpu_addr = 16'h0000;
    cpu_data = 8'h00;
  endtask

  task automatic next_cycle();
    if (clk_en) tb_put = ~tb_put;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clk_en  = 1'b0;
    bus_idle();
    tb_put = 1'b0;
    #13;
    n_cmp++;
    if ({o_cpu_rdy, o_dma_active, o_rw, o_address, o_data} !== {3'b101, 16'h0000, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b act=%b rw=%b addr=%h data=%h want 1 0 1 0000 00",
               o_cpu_rdy, o_dma_active, o_rw, o_address, o_data);
    end
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic test_idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      clk_en = 1'b1;
      bus_idle();
      @(posedge clk);
      n_cmp++;
      if ({o_cpu_rdy, o_dma_active, o_rw, o_address} !== {3'b101, 16'h0000}) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: got rdy=%b act=%b rw=%b addr=%h want 1 0 1 0000",
                 i, o_cpu_rdy, o_dma_active, o_rw, o_address);
      end
      next_cycle();
    end
  endtask

  // Trigger a transfer with the requested parity, then follow it to completion.
  // en_period: i_clk_en high on 1 of every en_period cycles. inject: cycle index for a
  // stray 4014 write of 8'h05 (-1 = none). abort_after: reset after this many writes (0 = none).
  task automatic run_dma(input logic [7:0] page, input bit want_align, input int en_period,
                         input int inject, input int abort_after, input string name);
    int          stall = 0;
    int          nwr = 0;
    bit          done = 1'b0;
    bit          prev_put = 1'b1;
    logic [15:0] prev_addr = 16'hxxxx;
    bit          en;
    // Trigger cycle parity p puts HALT on ~p; ALIGN appears when HALT is a get cycle.
    while (tb_put != want_align) begin
      clk_en = 1'b1;
      bus_idle();
      @(posedge clk);
      next_cycle();
    end
    clk_en   = 1'b1;
    cpu_rw   = 1'b0;
    cpu_addr = 16'h4014;
    cpu_data = page;
    @(posedge clk);
    next_cycle();
    for (int cyc = 0; cyc < 2500 && !done; cyc++) begin
      en = ((cyc % en_period) == 0) || (cyc == inject);
      clk_en = en;
      bus_idle();
      if (cyc == inject) begin
        cpu_rw   = 1'b0;
        cpu_addr = 16'h4014;
        cpu_data = 8'h05;
      end
      @(posedge clk);
      if (o_cpu_rdy) begin
        done = 1'b1;
      end else begin
        if (en) stall++;
        if (en && o_dma_active && !o_rw) begin
          n_cmp++;
          if (o_address !== 16'h2004 || o_data !== nwr[7:0] || prev_put !== 1'b0 ||
              prev_addr !== {page, nwr[7:0]}) begin
            n_fail++;
            $display("FAIL %s_write%0d: got addr=%h data=%h read_put=%b read_addr=%h want 2004 %h 0 %h",
                     name, nwr, o_address, o_data, prev_put, prev_addr, nwr[7:0], {page, nwr[7:0]});
          end
          nwr++;
          if (abort_after != 0 && nwr == abort_after) begin
            #2;
            reset_n = 1'b0;
            #1;
            n_cmp++;
            if ({o_cpu_rdy, o_dma_active, o_rw, o_address, o_data} !==
                {3'b101, 16'h0000, 8'h00}) begin
              n_fail++;
              $display("FAIL %s_abort_reset: got rdy=%b act=%b rw=%b addr=%h data=%h want 1 0 1 0000 00",
                       name, o_cpu_rdy, o_dma_active, o_rw, o_address, o_data);
            end
            clk_en = 1'b0;
            tb_put = 1'b0;
            @(negedge clk);
            #1;
            reset_n = 1'b1;
            @(negedge clk);
            #1;
            return;
          end
        end
        if (en) begin
          prev_put  = tb_put;
          prev_addr = o_address;
        end
      end
      if (!done) next_cycle();
    end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_timeout: transfer still stalling after 2500 cycles, want completion", name);
    end
    n_cmp++;
    if (stall != (want_align ? 514 : 513)) begin
      n_fail++;
      $display("FAIL %s_stall: got %0d enabled cycles want %0d", name, stall,
               want_align ? 514 : 513);
    end
    n_cmp++;
    if (nwr != 256) begin
      n_fail++;
      $display("FAIL %s_write_count: got %0d want 256", name, nwr);
    end
    // The final sample was taken at the rising edge; finish the cycle.
    next_cycle();
  endtask

  task automatic test_no_align();
    run_dma(8'h02, 1'b0, 1, -1, 0, "no_align");
  endtask

  task automatic test_align();
    run_dma(8'h02, 1'b1, 1, -1, 0, "align");
  endtask

  task automatic test_clk_en_page_ff();
    run_dma(8'hFF, 1'b0, 3, -1, 0, "clken_ff");
  endtask

  task automatic test_abort();
    run_dma(8'h02, 1'b0, 1, -1, 100, "abort");
    test_idle(5);
    run_dma(8'h03, 1'b1, 1, -1, 0, "restart");
  endtask

  task automatic test_ignore_retrigger();
    run_dma(8'h02, 1'b0, 1, 50, 0, "retrigger");
    test_idle(3);
  endtask

  initial begin
    test_reset();
    test_idle(10);
    test_no_align();
    test_align();
    test_clk_en_page_ff();
    test_abort();
    test_ignore_retrigger();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
